// File: rtl/led_matrix_pkg.sv
// Shared constants, scan state encoding and the column-slice helper for the
// LED matrix scan controller and the status decoders.
package led_matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int IMAGE_W  = NUM_COLS * NUM_ROWS;
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Column c of a column-packed image lives at bits [7c+6:7c].
  function automatic logic [NUM_ROWS-1:0] col_slice(input logic [IMAGE_W-1:0] img,
                                                    input logic [COL_W-1:0]   col);
    logic [IMAGE_W-1:0] shifted;
    shifted = img >> (int'(col) * NUM_ROWS);
    return shifted[NUM_ROWS-1:0];
  endfunction

endpackage

// File: rtl/led_matrix_scan_controller_if.sv
// Signal bundle between the image/status source (master) and the scan
// controller (slave), plus the controller's state for debug observation.
interface led_matrix_scan_controller_if;
  import led_matrix_pkg::*;

  // image_load is a one-cycle write strobe that is always accepted (no ready);
  // load_ack pulses once when the staged image reaches the display register.
  logic                enable;
  logic [IMAGE_W-1:0]  image_in;
  logic                image_load;
  logic                blink_en;
  logic [NUM_COLS-1:0] col_sel_n;
  logic [NUM_ROWS-1:0] row_data;
  logic                frame_start;
  logic                load_ack;
  scan_state_t         dbg_state;

  modport master (
    output enable, image_in, image_load, blink_en,
    input  col_sel_n, row_data, frame_start, load_ack, dbg_state
  );

  modport slave (
    input  enable, image_in, image_load, blink_en,
    output col_sel_n, row_data, frame_start, load_ack, dbg_state
  );

endinterface

// File: rtl/led_matrix_dwell_timer.sv
// Per-column dwell counter: counts 0..DWELL_CYCLES-1 while running and flags
// the last cycle of each dwell with a one-cycle dwell_done.
module led_matrix_dwell_timer #(
  parameter int DWELL_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic dwell_done
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DWELL_CYCLES - 1);

  logic [DW-1:0] count;

  assign dwell_done = run && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (run) begin
      count <= dwell_done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/led_matrix_scan_controller.sv
// Column-multiplexed scan of a 5x7 status image with a frame-synchronous
// double buffer and a frame-rate blink gate.
module led_matrix_scan_controller
  import led_matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLINK_FRAMES = 25
) (
  input logic                        clk,
  input logic                        rst_n,
  led_matrix_scan_controller_if.slave bus
);

  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);

  scan_state_t         state, state_nxt;
  logic [COL_W-1:0]    col, col_nxt;
  logic [IMAGE_W-1:0]  display, display_nxt;
  logic [IMAGE_W-1:0]  staging, staging_nxt;
  logic                pending, pending_nxt;
  logic [FW-1:0]       fcount, fcount_nxt;
  logic                phase, phase_nxt;
  logic [NUM_COLS-1:0] col_sel_q, col_sel_nxt;
  logic [NUM_ROWS-1:0] row_q, row_nxt;
  logic                frame_start_q, load_ack_q;
  logic                dwell_done, entering, frame_end, boundary, swap;

  // Cleared for the whole of IDLE so the first SCAN cycle always starts at 0.
  led_matrix_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != SCAN),
    .run        ((state == SCAN) && bus.enable),
    .dwell_done (dwell_done)
  );

  always_comb begin
    state_nxt   = bus.enable ? SCAN : IDLE;
    entering    = (state == IDLE) && bus.enable;
    frame_end   = dwell_done && (col == COL_LAST);
    boundary    = entering || frame_end;

    col_nxt = col;
    if (!bus.enable || entering)  col_nxt = '0;
    else if (dwell_done)          col_nxt = (col == COL_LAST) ? '0 : col + 1'b1;

    // A load on the boundary cycle is folded in first, giving write-through.
    staging_nxt = bus.image_load ? bus.image_in : staging;
    pending_nxt = pending || bus.image_load;
    display_nxt = display;
    swap        = 1'b0;
    if (boundary && pending_nxt) begin
      swap        = 1'b1;
      display_nxt = staging_nxt;
      pending_nxt = 1'b0;
    end

    fcount_nxt = fcount;
    phase_nxt  = phase;
    if (!bus.enable) begin
      fcount_nxt = '0;
      phase_nxt  = 1'b0;
    end else if (frame_end) begin
      if (fcount == FRAME_LAST) begin
        fcount_nxt = '0;
        phase_nxt  = ~phase;
      end else begin
        fcount_nxt = fcount + 1'b1;
      end
    end

    col_sel_nxt = '1;
    row_nxt     = '0;
    if (state_nxt == SCAN) begin
      col_sel_nxt = ~(NUM_COLS'(1) << col_nxt);
      if (!(bus.blink_en && phase_nxt)) row_nxt = col_slice(display_nxt, col_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      col           <= '0;
      display       <= '0;
      staging       <= '0;
      pending       <= 1'b0;
      fcount        <= '0;
      phase         <= 1'b0;
      col_sel_q     <= '1;
      row_q         <= '0;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      state         <= state_nxt;
      col           <= col_nxt;
      display       <= display_nxt;
      staging       <= staging_nxt;
      pending       <= pending_nxt;
      fcount        <= fcount_nxt;
      phase         <= phase_nxt;
      col_sel_q     <= col_sel_nxt;
      row_q         <= row_nxt;
      frame_start_q <= boundary;
      load_ack_q    <= swap;
    end
  end

  assign bus.col_sel_n   = col_sel_q;
  assign bus.row_data    = row_q;
  assign bus.frame_start = frame_start_q;
  assign bus.load_ack    = load_ack_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// Bench for led_matrix_scan_controller: time-since-entry reference model
// checked every cycle, plus directed literal expectations for each scenario.
module tb_led_matrix_scan_controller;
  import led_matrix_pkg::*;

  localparam int D = 4;
  localparam int B = 2;
  localparam int FRAME = 5 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  always #5 clk = ~clk;

  led_matrix_scan_controller_if bus ();

  led_matrix_scan_controller #(.DWELL_CYCLES(D), .BLINK_FRAMES(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  logic        m_on = 1'b0;
  int          m_t  = 0;
  logic        m_pend = 1'b0;
  logic [34:0] m_disp = '0;
  logic [34:0] m_stage = '0;
  logic [4:0]  exp_col = 5'h1f;
  logic [6:0]  exp_row = 7'h00;
  logic        exp_fs = 1'b0;
  logic        exp_ack = 1'b0;

  always @(posedge clk) begin : model
    logic        on, pend, bnd, ack, ph;
    int          t, col, frame;
    logic [34:0] disp, stage, sh;
    on = m_on; t = m_t; pend = m_pend; disp = m_disp; stage = m_stage;
    bnd = 1'b0; ack = 1'b0;
    if (!rst_n) begin
      on = 1'b0; t = 0; pend = 1'b0; disp = '0; stage = '0;
    end else begin
      if (bus.enable) begin
        if (!on) begin
          on = 1'b1; t = 0; bnd = 1'b1;
        end else begin
          t = t + 1;
          bnd = (t % FRAME) == 0;
        end
      end else begin
        on = 1'b0; t = 0;
      end
      if (bus.image_load) begin
        stage = bus.image_in; pend = 1'b1;
      end
      ack = bnd && pend;
      if (ack) begin
        disp = stage; pend = 1'b0;
      end
    end
    col   = (t / D) % 5;
    frame = t / FRAME;
    ph    = ((frame / B) % 2) == 1;
    sh    = disp >> (col * 7);
    m_on <= on; m_t <= t; m_pend <= pend; m_disp <= disp; m_stage <= stage;
    exp_col <= on ? ~(5'b00001 << col) : 5'h1f;
    exp_row <= (on && !(bus.blink_en && ph)) ? sh[6:0] : 7'h00;
    exp_fs  <= bnd;
    exp_ack <= ack;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("col_sel_n", bus.col_sel_n, exp_col);
      check("row_data", bus.row_data, exp_row);
      check("frame_start", bus.frame_start, exp_fs);
      check("load_ack", bus.load_ack, exp_ack);
      check("state", bus.dbg_state, m_on ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [34:0] img);
    bus.image_in   = img;
    bus.image_load = 1'b1;
    tick(1);
    bus.image_load = 1'b0;
  endtask

  task automatic pin(input string tag, input logic [4:0] c, input logic [6:0] r,
                     input logic fs, input logic ack);
    check({tag, ".col"}, bus.col_sel_n, c);
    check({tag, ".row"}, bus.row_data, r);
    check({tag, ".fs"},  bus.frame_start, fs);
    check({tag, ".ack"}, bus.load_ack, ack);
  endtask

  initial begin
    bus.enable = 1'b0; bus.image_in = '0; bus.image_load = 1'b0; bus.blink_en = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    pin("reset", 5'h1f, 7'h00, 1'b0, 1'b0);

    // 1: preload in IDLE, then scan; swap lands on the entry cycle
    load(35'h0_0000_007F);
    bus.enable = 1'b1;
    tick(1);                                       // t=0
    pin("t1_entry", 5'b11110, 7'h7F, 1'b1, 1'b1);
    tick(4);                                       // t=4
    pin("t1_col1", 5'b11101, 7'h00, 1'b0, 1'b0);
    tick(12);                                      // t=16
    pin("t1_col4", 5'b01111, 7'h00, 1'b0, 1'b0);
    tick(4);                                       // t=20
    pin("t1_frame1", 5'b11110, 7'h7F, 1'b1, 1'b0);

    // 2: mid-frame load at column 2 waits for the boundary
    tick(8);                                       // t=28
    load(35'h7_F000_0000);                         // t=29
    tick(10);                                      // t=39
    pin("t2_old_col4", 5'b01111, 7'h00, 1'b0, 1'b0);
    tick(1);                                       // t=40
    pin("t2_swap", 5'b11110, 7'h00, 1'b1, 1'b1);
    tick(16);                                      // t=56
    pin("t2_col4", 5'b01111, 7'h7F, 1'b0, 1'b0);

    // 3: two loads in one frame, only the last one shows
    load(35'h0_0000_0055);                         // t=57
    tick(1);                                       // t=58
    load(35'h0_0000_002A);                         // t=59
    tick(1);                                       // t=60
    pin("t3_swap", 5'b11110, 7'h2A, 1'b1, 1'b1);
    tick(20);                                      // t=80
    pin("t3_next", 5'b11110, 7'h2A, 1'b1, 1'b0);

    // 4: load on the column-4 dwell end writes through
    tick(19);                                      // t=99
    load(35'h0_0000_0033);                         // t=100
    pin("t4_swap", 5'b11110, 7'h33, 1'b1, 1'b1);
    tick(20);                                      // t=120
    pin("t4_next", 5'b11110, 7'h33, 1'b1, 1'b0);

    // 5: blink with BLINK_FRAMES=2 after a fresh entry
    bus.enable = 1'b0;
    tick(1);
    pin("t5_off", 5'h1f, 7'h00, 1'b0, 1'b0);
    bus.enable = 1'b1; bus.blink_en = 1'b1;
    tick(1);                                       // t=0
    pin("t5_f0", 5'b11110, 7'h33, 1'b1, 1'b0);
    tick(40);                                      // t=40
    pin("t5_f2", 5'b11110, 7'h00, 1'b1, 1'b0);
    tick(40);                                      // t=80
    pin("t5_f4", 5'b11110, 7'h33, 1'b1, 1'b0);
    bus.blink_en = 1'b0;

    // 6: disable in column 3, re-enable, then reset with a pending image
    tick(12);                                      // t=92, column 3
    bus.enable = 1'b0;
    tick(1);
    pin("t6_off", 5'h1f, 7'h00, 1'b0, 1'b0);
    bus.enable = 1'b1;
    tick(1);                                       // t=0
    pin("t6_reentry", 5'b11110, 7'h33, 1'b1, 1'b0);
    tick(12);                                      // t=12, column 3
    load(35'h0_0000_0011);
    rst_n = 1'b0;
    tick(1);
    pin("t6_reset", 5'h1f, 7'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1);
    pin("t6_after_rst", 5'b11110, 7'h00, 1'b1, 1'b0);
    tick(20);
    pin("t6_frame1", 5'b11110, 7'h00, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
